// File: rtl/lift_call_sched_if.sv
// rtl/lift_call_sched_if.sv - scheduler <-> lift controller handshake bundle
interface lift_call_sched_if;
  logic [2:0] elev_f_i;  // current car floor reported by the lift
  logic       busy_i;    // lift busy flag
  logic [2:0] pass_f_o;  // target floor presented to the lift
  logic       req_o;     // call strobe to the lift

  // scheduler side
  modport master (
    input  elev_f_i,
    input  busy_i,
    output pass_f_o,
    output req_o
  );

  // lift side
  modport slave (
    output elev_f_i,
    output busy_i,
    input  pass_f_o,
    input  req_o
  );
endinterface

// File: rtl/lift_call_sched.sv
// rtl/lift_call_sched.sv - collective hall-call scheduler for a single lift car (optional LIFT_CALL_CANCEL_EN adds cancel_i)
module lift_call_sched #(
  parameter int NUM_FLOORS  = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lift_call_sched_if.master     lift,
  input  logic [NUM_FLOORS-1:0] call_up_i,
  input  logic [NUM_FLOORS-1:0] call_dn_i,
`ifdef LIFT_CALL_CANCEL_EN
  input  logic [NUM_FLOORS-1:0] cancel_i,
`endif
  output logic [NUM_FLOORS-1:0] pend_o,
  output logic                  dir_o
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_SERVE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_FLOORS-1:0] r_pend;
  logic [NUM_FLOORS-1:0] w_pend_nxt;
  logic                  r_dir;
  logic                  w_dir_nxt;
  logic [2:0]            r_pass_f;
  logic [2:0]            w_pass_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_cancel;
  logic [NUM_FLOORS-1:0] w_tgt_mask;
  logic [2:0]            w_elev;
  logic                  w_at;
  logic                  w_above_ok;
  logic [2:0]            w_above;
  logic                  w_below_ok;
  logic [2:0]            w_below;

`ifdef LIFT_CALL_CANCEL_EN
  assign w_cancel = cancel_i;
`else
  assign w_cancel = '0;
`endif

  // An out-of-range car position is treated as the ground floor.
  assign w_elev = (lift.elev_f_i >= 3'd1 && int'(lift.elev_f_i) <= NUM_FLOORS)
                  ? lift.elev_f_i : 3'd1;

  assign w_tgt_mask = ONE << (r_pass_f - 3'd1);

  // A new press in the same cycle as a clear or cancel keeps the bit set.
  assign w_pend_nxt = (r_pend & ~w_clr & ~w_cancel) | call_up_i | call_dn_i;

  // Search pending floors: at the car, nearest above, nearest below.
  always_comb begin
    w_at       = 1'b0;
    w_above_ok = 1'b0;
    w_above    = 3'd1;
    w_below_ok = 1'b0;
    w_below    = 3'd1;
    for (int f = NUM_FLOORS; f >= 1; f--) begin
      if (r_pend[f-1] && f > int'(w_elev)) begin
        w_above_ok = 1'b1;
        w_above    = 3'(f);
      end
    end
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (r_pend[f-1] && f < int'(w_elev)) begin
        w_below_ok = 1'b1;
        w_below    = 3'(f);
      end
      if (r_pend[f-1] && f == int'(w_elev)) begin
        w_at = 1'b1;
      end
    end
  end

  // Next-state, target/direction choice, ack timeout and service clear.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_pass_nxt  = r_pass_f;
    w_cnt_nxt   = '0;
    w_clr       = '0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (r_pend == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
          if (w_at) begin
            w_pass_nxt = w_elev;
          end else if (r_dir) begin
            if (w_above_ok) begin
              w_pass_nxt = w_above;
            end else begin
              w_dir_nxt  = 1'b0;
              w_pass_nxt = w_below;
            end
          end else begin
            if (w_below_ok) begin
              w_pass_nxt = w_below;
            end else begin
              w_dir_nxt  = 1'b1;
              w_pass_nxt = w_above;
            end
          end
        end
      end
      S_REQ: begin
        if (lift.busy_i) begin
          w_state_nxt = S_SERVE;
        end else if (|(w_cancel & w_tgt_mask)) begin
          w_state_nxt = S_SELECT;
        end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = S_SELECT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SERVE: begin
        if (!lift.busy_i) begin
          w_state_nxt = S_IDLE;
          if (lift.elev_f_i == r_pass_f) w_clr = w_tgt_mask;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pending calls, sweep direction, target floor and ack counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_dir    <= 1'b1;
      r_pass_f <= 3'd1;
      r_cnt    <= '0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_dir    <= w_dir_nxt;
      r_pass_f <= w_pass_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign lift.req_o    = (r_state == S_REQ);
  assign lift.pass_f_o = r_pass_f;
  assign pend_o        = r_pend;
  assign dir_o         = r_dir;

endmodule

// File: tb/tb_lift_call_sched.sv
// tb/tb_lift_call_sched.sv - directed self-checking bench for lift_call_sched
module tb_lift_call_sched;
  logic       clk;
  logic       rst_n;
  logic [6:0] call_up;
  logic [6:0] call_dn;
  logic [6:0] pend;
  logic       dir;
`ifdef LIFT_CALL_CANCEL_EN
  logic [6:0] cancel;
`endif
  int         n_chk;
  int         n_fail;
  logic       stay;

  lift_call_sched_if u_if ();

  lift_call_sched #(.NUM_FLOORS(7), .ACK_TIMEOUT(15)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lift      (u_if),
    .call_up_i (call_up),
    .call_dn_i (call_dn),
`ifdef LIFT_CALL_CANCEL_EN
    .cancel_i  (cancel),
`endif
    .pend_o    (pend),
    .dir_o     (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    call_up = '0;
    call_dn = '0;
`ifdef LIFT_CALL_CANCEL_EN
    cancel = '0;
`endif
    u_if.elev_f_i = 3'd1;
    u_if.busy_i   = 1'b0;
    tick();
    tick();
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_req", 32'(u_if.req_o), 32'h0);
    chk("rst_pass", 32'(u_if.pass_f_o), 32'h1);
    chk("rst_dir", 32'(dir), 32'h1);
    rst_n = 1'b1;
    tick();

    // single call at floor 5, car at 1
    call_up = 7'b0010000;
    tick();
    call_up = '0;
    chk("t1_pend_set", 32'(pend), 32'h10);
    chk("t1_req_idle", 32'(u_if.req_o), 32'h0);
    tick();
    chk("t1_req_select", 32'(u_if.req_o), 32'h0);
    tick();
    chk("t1_req_on", 32'(u_if.req_o), 32'h1);
    chk("t1_pass", 32'(u_if.pass_f_o), 32'h5);
    chk("t1_dir", 32'(dir), 32'h1);
    u_if.busy_i = 1'b1;
    tick();
    chk("t1_req_serve", 32'(u_if.req_o), 32'h0);
    u_if.elev_f_i = 3'd5;
    u_if.busy_i   = 1'b0;
    tick();
    chk("t1_pend_clr", 32'(pend), 32'h0);
    tick();
    tick();
    chk("t1_idle_req", 32'(u_if.req_o), 32'h0);

    // car at 3 going up, calls at 2 and 6
    u_if.elev_f_i = 3'd3;
    call_dn = 7'b0000010;
    call_up = 7'b0100000;
    tick();
    call_dn = '0;
    call_up = '0;
    chk("t2_pend", 32'(pend), 32'h22);
    tick();
    tick();
    chk("t2_req", 32'(u_if.req_o), 32'h1);
    chk("t2_pass6", 32'(u_if.pass_f_o), 32'h6);
    chk("t2_dir_up", 32'(dir), 32'h1);
    u_if.busy_i = 1'b1;
    tick();
    u_if.elev_f_i = 3'd6;
    u_if.busy_i   = 1'b0;
    tick();
    chk("t2_pend_after6", 32'(pend), 32'h02);
    tick();
    tick();
    chk("t2_req2", 32'(u_if.req_o), 32'h1);
    chk("t2_pass2", 32'(u_if.pass_f_o), 32'h2);
    chk("t2_dir_dn", 32'(dir), 32'h0);

    // ack timeout: 15 REQ cycles, one SELECT cycle, REQ again
    stay = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (u_if.req_o !== 1'b1) stay = 1'b0;
    end
    chk("t3_req_held", 32'(stay), 32'h1);
    tick();
    chk("t3_req_drop", 32'(u_if.req_o), 32'h0);
    tick();
    chk("t3_req_again", 32'(u_if.req_o), 32'h1);
    chk("t3_pass", 32'(u_if.pass_f_o), 32'h2);
    chk("t3_dir", 32'(dir), 32'h0);

    // busy falls at the wrong floor: call is kept and re-requested
    u_if.busy_i = 1'b1;
    tick();
    u_if.elev_f_i = 3'd4;
    u_if.busy_i   = 1'b0;
    tick();
    chk("t4_pend_kept", 32'(pend), 32'h02);
    tick();
    tick();
    chk("t4_rereq", 32'(u_if.req_o), 32'h1);
    chk("t4_pass", 32'(u_if.pass_f_o), 32'h2);

    // press on the target floor in its clear cycle keeps the bit
    u_if.busy_i = 1'b1;
    tick();
    u_if.elev_f_i = 3'd2;
    u_if.busy_i   = 1'b0;
    call_dn       = 7'b0000010;
    tick();
    call_dn = '0;
    chk("t4_press_wins", 32'(pend), 32'h02);
    tick();
    tick();
    chk("t4_req_at_car", 32'(u_if.req_o), 32'h1);
    chk("t4_pass_at_car", 32'(u_if.pass_f_o), 32'h2);

    // asynchronous reset mid-REQ with three calls pending
    call_up = 7'b1101000;
    tick();
    call_up = '0;
    chk("t5_pend_pre", 32'(pend), 32'h6a);
    chk("t5_req_pre", 32'(u_if.req_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_req_rst", 32'(u_if.req_o), 32'h0);
    chk("t5_pend_rst", 32'(pend), 32'h0);
    chk("t5_pass_rst", 32'(u_if.pass_f_o), 32'h1);
    chk("t5_dir_rst", 32'(dir), 32'h1);
    tick();
    rst_n = 1'b1;
    u_if.elev_f_i = 3'd1;
    tick();
    chk("t5_idle_after", 32'(u_if.req_o), 32'h0);

`ifdef LIFT_CALL_CANCEL_EN
    // cancel the current target while requesting
    call_up = 7'b0010100;
    tick();
    call_up = '0;
    tick();
    tick();
    chk("t6_req", 32'(u_if.req_o), 32'h1);
    chk("t6_pass3", 32'(u_if.pass_f_o), 32'h3);
    cancel = 7'b0000100;
    tick();
    cancel = '0;
    chk("t6_req_drop", 32'(u_if.req_o), 32'h0);
    chk("t6_pend", 32'(pend), 32'h10);
    tick();
    chk("t6_req_new", 32'(u_if.req_o), 32'h1);
    chk("t6_pass5", 32'(u_if.pass_f_o), 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
